// File: rtl/branch_pred_pkg.sv
// Shared branch-prediction types: queued prediction record and 2-bit counter state encoding.
package branch_pred_pkg;

    localparam int BRQ_DATA_WIDTH  = 16;
    localparam int BRQ_INDEX_WIDTH = 6;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef struct packed {
        logic [BRQ_INDEX_WIDTH-1:0] address;
        logic                       hit;
        logic [1:0]                 prediction;
        logic [BRQ_DATA_WIDTH-1:0]  predicted_destination;
        logic [BRQ_DATA_WIDTH-1:0]  fallthrough;
    } branch_queue_entry_t;

endpackage

// File: rtl/branch_outcome_compare.sv
// Compares a recorded prediction against the resolved outcome; pure combinational.
module branch_outcome_compare
    import branch_pred_pkg::*;
(
    input  branch_queue_entry_t        entry,
    input  logic                       resolve_taken,
    input  logic [BRQ_DATA_WIDTH-1:0]  resolve_destination,
    output logic                       mispredict,
    output logic [BRQ_DATA_WIDTH-1:0]  redirect_pc
);

    logic predicted_taken;

    // A miss in the target buffer always counts as a not-taken prediction.
    assign predicted_taken = entry.hit && (entry.prediction inside {WEAK_T, STRONG_T});

    assign mispredict = (predicted_taken != resolve_taken) ||
                        (predicted_taken && resolve_taken &&
                         (entry.predicted_destination != resolve_destination));

    assign redirect_pc = resolve_taken ? resolve_destination : entry.fallthrough;

endmodule

// File: rtl/branch_resolution_queue.sv
// In-order queue of outstanding branch predictions; resolves the oldest and emits update/redirect pulses.
module branch_resolution_queue
    import branch_pred_pkg::*;
#(
    parameter int DATABITWIDTH           = BRQ_DATA_WIDTH,
    parameter int PREDICTORDEPTH         = 64,
    parameter int PREDICTORINDEXBITWIDTH = (PREDICTORDEPTH > 1) ? $clog2(PREDICTORDEPTH) : 1,
    parameter int QUEUEDEPTH             = 8,
    parameter int QUEUEINDEXBITWIDTH     = $clog2(QUEUEDEPTH)
) (
    input  logic                              clk,
    input  logic                              sync_rst_n,
    input  logic                              clk_en,
    input  logic                              PredictValid,
    output logic                              PredictReady,
    input  logic [PREDICTORINDEXBITWIDTH-1:0] PredictAddress,
    input  logic                              PredictionValidIn,
    input  logic [1:0]                        PredictionIn,
    input  logic [DATABITWIDTH-1:0]           PredictedDestinationIn,
    input  logic [DATABITWIDTH-1:0]           FallthroughPC,
    input  logic                              ResolveValid,
    input  logic                              ResolveTaken,
    input  logic [DATABITWIDTH-1:0]           ResolveDestination,
    output logic                              UpdateEnable,
    output logic [PREDICTORINDEXBITWIDTH-1:0] UpdateAddress,
    output logic [DATABITWIDTH-1:0]           UpdateDestination,
    output logic                              UpdateTaken,
    output logic                              Mispredict,
    output logic [DATABITWIDTH-1:0]           RedirectPC,
    output logic                              ResolveUnderflow,
    output logic [QUEUEINDEXBITWIDTH:0]       Occupancy,
    output logic                              QueueEmpty,
    output logic                              QueueFull
);

    branch_queue_entry_t entries [QUEUEDEPTH];

    logic [QUEUEINDEXBITWIDTH:0] head;
    logic [QUEUEINDEXBITWIDTH:0] tail;

    branch_queue_entry_t new_entry;
    branch_queue_entry_t head_entry;
    logic                do_enqueue;
    logic                do_resolve;
    logic                resolve_mispredict;
    logic [DATABITWIDTH-1:0] resolve_redirect;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign QueueEmpty   = (head == tail);
    assign QueueFull    = (head[QUEUEINDEXBITWIDTH] != tail[QUEUEINDEXBITWIDTH]) &&
                          (head[QUEUEINDEXBITWIDTH-1:0] == tail[QUEUEINDEXBITWIDTH-1:0]);
    assign Occupancy    = tail - head;
    assign PredictReady = sync_rst_n && !QueueFull;

    assign do_enqueue = clk_en && PredictValid && PredictReady;
    assign do_resolve = clk_en && ResolveValid && !QueueEmpty;

    assign new_entry.address               = PredictAddress;
    assign new_entry.hit                   = PredictionValidIn;
    assign new_entry.prediction            = PredictionIn;
    assign new_entry.predicted_destination = PredictedDestinationIn;
    assign new_entry.fallthrough           = FallthroughPC;

    assign head_entry = entries[head[QUEUEINDEXBITWIDTH-1:0]];

    branch_outcome_compare u_compare (
        .entry               (head_entry),
        .resolve_taken       (ResolveTaken),
        .resolve_destination (ResolveDestination),
        .mispredict          (resolve_mispredict),
        .redirect_pc         (resolve_redirect)
    );

    // A write landing just before a mispredict flush is harmless: the pointers discard it.
    always_ff @(posedge clk) begin
        if (do_enqueue) begin
            entries[tail[QUEUEINDEXBITWIDTH-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            head              <= '0;
            tail              <= '0;
            UpdateEnable      <= 1'b0;
            UpdateAddress     <= '0;
            UpdateDestination <= '0;
            UpdateTaken       <= 1'b0;
            Mispredict        <= 1'b0;
            RedirectPC        <= '0;
            ResolveUnderflow  <= 1'b0;
        end else if (clk_en) begin
            if (do_resolve && resolve_mispredict) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_enqueue) tail <= tail + 1'b1;
                if (do_resolve) head <= head + 1'b1;
            end
            UpdateEnable     <= do_resolve;
            Mispredict       <= do_resolve && resolve_mispredict;
            ResolveUnderflow <= ResolveValid && QueueEmpty;
            if (do_resolve) begin
                UpdateAddress     <= head_entry.address;
                UpdateDestination <= ResolveDestination;
                UpdateTaken       <= ResolveTaken;
                RedirectPC        <= resolve_redirect;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and random traffic against a queue model.
module tb_branch_resolution_queue;
    import branch_pred_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        sync_rst_n;
    logic        clk_en;
    logic        predict_valid;
    logic        predict_ready;
    logic [5:0]  predict_address;
    logic        prediction_valid_in;
    logic [1:0]  prediction_in;
    logic [15:0] predicted_destination_in;
    logic [15:0] fallthrough_pc;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [15:0] resolve_destination;
    logic        update_enable;
    logic [5:0]  update_address;
    logic [15:0] update_destination;
    logic        update_taken;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic        resolve_underflow;
    logic [3:0]  occupancy;
    logic        queue_empty;
    logic        queue_full;

    always #5 clk = ~clk;

    branch_resolution_queue dut (
        .clk                    (clk),
        .sync_rst_n             (sync_rst_n),
        .clk_en                 (clk_en),
        .PredictValid           (predict_valid),
        .PredictReady           (predict_ready),
        .PredictAddress         (predict_address),
        .PredictionValidIn      (prediction_valid_in),
        .PredictionIn           (prediction_in),
        .PredictedDestinationIn (predicted_destination_in),
        .FallthroughPC          (fallthrough_pc),
        .ResolveValid           (resolve_valid),
        .ResolveTaken           (resolve_taken),
        .ResolveDestination     (resolve_destination),
        .UpdateEnable           (update_enable),
        .UpdateAddress          (update_address),
        .UpdateDestination      (update_destination),
        .UpdateTaken            (update_taken),
        .Mispredict             (mispredict),
        .RedirectPC             (redirect_pc),
        .ResolveUnderflow       (resolve_underflow),
        .Occupancy              (occupancy),
        .QueueEmpty             (queue_empty),
        .QueueFull              (queue_full)
    );

    typedef struct {
        logic [5:0]  addr;
        logic        hit;
        logic [1:0]  pred;
        logic [15:0] dest;
        logic [15:0] fall;
    } rec_t;

    typedef struct {
        logic        pv;
        logic [5:0]  addr;
        logic        hit;
        logic [1:0]  pred;
        logic [15:0] dest;
        logic [15:0] fall;
        logic        rv;
        logic        rt;
        logic [15:0] rdest;
        logic        e_upd;
        logic [5:0]  e_addr;
        logic        e_taken;
        logic        e_mis;
        logic [15:0] e_redir;
        logic        e_under;
        int          e_occ;
    } vec_t;

    vec_t vecs[$];
    rec_t model_q[$];

    logic        m_upd;
    logic [5:0]  m_addr;
    logic [15:0] m_dest;
    logic        m_taken;
    logic        m_mis;
    logic [15:0] m_redir;
    logic        m_under;

    int checks = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic pv, input logic [5:0] addr, input logic hit,
                                  input logic [1:0] pred, input logic [15:0] dest, input logic [15:0] fall,
                                  input logic rv, input logic rt, input logic [15:0] rdest);
        predict_valid            = pv;
        predict_address          = addr;
        prediction_valid_in      = hit;
        prediction_in            = pred;
        predicted_destination_in = dest;
        fallthrough_pc           = fall;
        resolve_valid            = rv;
        resolve_taken            = rt;
        resolve_destination      = rdest;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 6'd0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    // Reference: a FIFO of records; resolve pops the front and a mispredict empties the FIFO.
    task automatic step_model();
        bit   accept;
        bit   flushed;
        bit   pred_taken;
        rec_t e;
        rec_t n;
        if (!sync_rst_n) begin
            model_q.delete();
            m_upd = 0; m_addr = 0; m_dest = 0; m_taken = 0; m_mis = 0; m_redir = 0; m_under = 0;
        end else if (clk_en) begin
            accept  = predict_valid && (model_q.size() < DEPTH);
            flushed = 0;
            m_upd   = 0;
            m_mis   = 0;
            m_under = 0;
            if (resolve_valid) begin
                if (model_q.size() == 0) begin
                    m_under = 1;
                end else begin
                    e = model_q.pop_front();
                    pred_taken = e.hit && (e.pred >= 2);
                    m_mis   = (pred_taken != resolve_taken) ||
                              (pred_taken && resolve_taken && e.dest != resolve_destination);
                    m_upd   = 1;
                    m_addr  = e.addr;
                    m_dest  = resolve_destination;
                    m_taken = resolve_taken;
                    m_redir = resolve_taken ? resolve_destination : e.fall;
                    if (m_mis) begin
                        model_q.delete();
                        flushed = 1;
                    end
                end
            end
            if (accept && !flushed) begin
                n.addr = predict_address;
                n.hit  = prediction_valid_in;
                n.pred = prediction_in;
                n.dest = predicted_destination_in;
                n.fall = fallthrough_pc;
                model_q.push_back(n);
            end
        end
    endtask

    task automatic check_model();
        check_output("update_enable", update_enable, m_upd);
        check_output("mispredict", mispredict, m_mis);
        check_output("underflow", resolve_underflow, m_under);
        check_output("update_address", update_address, m_addr);
        check_output("update_destination", update_destination, m_dest);
        check_output("update_taken", update_taken, m_taken);
        check_output("redirect_pc", redirect_pc, m_redir);
        check_output("occupancy", occupancy, model_q.size());
        check_output("queue_empty", queue_empty, model_q.size() == 0);
        check_output("queue_full", queue_full, model_q.size() == DEPTH);
        check_output("predict_ready", predict_ready, sync_rst_n && (model_q.size() < DEPTH));
    endtask

    task automatic run_cycle();
        step_model();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic add_vec(input logic pv, input logic [5:0] addr, input logic hit, input logic [1:0] pred,
                           input logic [15:0] dest, input logic [15:0] fall,
                           input logic rv, input logic rt, input logic [15:0] rdest,
                           input logic e_upd, input logic [5:0] e_addr, input logic e_taken,
                           input logic e_mis, input logic [15:0] e_redir, input logic e_under, input int e_occ);
        vec_t v;
        v.pv = pv; v.addr = addr; v.hit = hit; v.pred = pred; v.dest = dest; v.fall = fall;
        v.rv = rv; v.rt = rt; v.rdest = rdest;
        v.e_upd = e_upd; v.e_addr = e_addr; v.e_taken = e_taken; v.e_mis = e_mis;
        v.e_redir = e_redir; v.e_under = e_under; v.e_occ = e_occ;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        saved_upd;
        logic        saved_mis;
        logic [15:0] saved_redir;
        logic [3:0]  saved_occ;

        sync_rst_n = 1'b0;
        clk_en     = 1'b1;
        idle();
        run_cycle();
        run_cycle();
        check_output("reset_empty", queue_empty, 1);
        check_output("reset_ready", predict_ready, 0);
        sync_rst_n = 1'b1;
        #1;
        check_output("ready_after_reset", predict_ready, 1);

        //      pv addr hit pred      dest     fall     rv rt rdest     upd addr tk mis redir    und occ
        add_vec(1, 5,  1, STRONG_T, 16'h040, 16'h006, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  1);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 1, 16'h040,  1,  5,   1, 0,  16'h040, 0,  0);
        add_vec(1, 5,  1, STRONG_T, 16'h040, 16'h006, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  1);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 1, 16'h080,  1,  5,   1, 1,  16'h080, 0,  0);
        add_vec(1, 3,  0, STRONG_NT,16'h000, 16'h012, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  1);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 0, 16'h000,  1,  3,   0, 0,  16'h012, 0,  0);
        add_vec(1, 3,  0, STRONG_NT,16'h000, 16'h012, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  1);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 1, 16'h100,  1,  3,   1, 1,  16'h100, 0,  0);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 0, 16'h000,  0,  0,   0, 0,  16'h000, 1,  0);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  0);
        add_vec(1, 7,  1, WEAK_T,   16'h200, 16'h020, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  1);
        add_vec(1, 9,  1, WEAK_NT,  16'h300, 16'h030, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  2);
        add_vec(1, 10, 1, STRONG_T, 16'h050, 16'h060, 1, 0, 16'h000,  1,  7,   0, 1,  16'h020, 0,  0);
        add_vec(1, 11, 1, STRONG_T, 16'h044, 16'h008, 1, 1, 16'h044,  0,  0,   0, 0,  16'h000, 1,  1);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 1, 16'h044,  1,  11,  1, 0,  16'h044, 0,  0);
        add_vec(1, 12, 1, WEAK_NT,  16'h070, 16'h00C, 0, 0, 16'h000,  0,  0,   0, 0,  16'h000, 0,  1);
        add_vec(0, 0,  0, STRONG_NT,16'h000, 16'h000, 1, 0, 16'h000,  1,  12,  0, 0,  16'h00C, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].pv, vecs[i].addr, vecs[i].hit, vecs[i].pred, vecs[i].dest,
                           vecs[i].fall, vecs[i].rv, vecs[i].rt, vecs[i].rdest);
            run_cycle();
            check_output($sformatf("vec%0d_upd", i), update_enable, vecs[i].e_upd);
            check_output($sformatf("vec%0d_mis", i), mispredict, vecs[i].e_mis);
            check_output($sformatf("vec%0d_under", i), resolve_underflow, vecs[i].e_under);
            check_output($sformatf("vec%0d_occ", i), occupancy, vecs[i].e_occ);
            if (vecs[i].e_upd) begin
                check_output($sformatf("vec%0d_addr", i), update_address, vecs[i].e_addr);
                check_output($sformatf("vec%0d_taken", i), update_taken, vecs[i].e_taken);
                check_output($sformatf("vec%0d_redir", i), redirect_pc, vecs[i].e_redir);
            end
        end

        // Fill to capacity; the ninth record must be refused.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 6'(i), 1'b0, STRONG_NT, 16'h0, 16'(i), 1'b0, 1'b0, 16'h0);
            run_cycle();
        end
        check_output("fill_full", queue_full, 1);
        check_output("fill_occ", occupancy, 8);
        check_output("fill_ready", predict_ready, 0);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 6'd0, 1'b0, STRONG_NT, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
            run_cycle();
            check_output($sformatf("drain%0d_addr", i), update_address, i);
        end
        idle();
        run_cycle();
        check_output("drain_empty", queue_empty, 1);

        // Interleaved enqueue/resolve pairs walk both pointers around the ring.
        apply_stimulus(1'b1, 6'd40, 1'b0, STRONG_NT, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        run_cycle();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 6'(41 + i), 1'b0, STRONG_NT, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
            run_cycle();
            check_output($sformatf("wrap%0d_addr", i), update_address, 40 + i);
        end
        idle();
        run_cycle();

        // A resolve pulse is held while clk_en is low, even with new traffic offered.
        apply_stimulus(1'b0, 6'd0, 1'b0, STRONG_NT, 16'h0, 16'h0, 1'b1, 1'b1, 16'h099);
        run_cycle();
        check_output("hold_setup_mis", mispredict, 1);
        saved_upd   = update_enable;
        saved_mis   = mispredict;
        saved_redir = redirect_pc;
        saved_occ   = occupancy;
        clk_en = 1'b0;
        apply_stimulus(1'b1, 6'd33, 1'b1, STRONG_T, 16'h055, 16'h011, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check_output($sformatf("hold%0d_upd", i), update_enable, saved_upd);
            check_output($sformatf("hold%0d_mis", i), mispredict, saved_mis);
            check_output($sformatf("hold%0d_redir", i), redirect_pc, saved_redir);
            check_output($sformatf("hold%0d_occ", i), occupancy, saved_occ);
        end
        clk_en = 1'b1;
        idle();
        run_cycle();

        // Reset mid-stream wins over clk_en low.
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1'b1, 6'(i), 1'b0, STRONG_NT, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
            run_cycle();
        end
        apply_stimulus(1'b0, 6'd0, 1'b0, STRONG_NT, 16'h0, 16'h0, 1'b1, 1'b1, 16'h077);
        run_cycle();
        sync_rst_n = 1'b0;
        clk_en     = 1'b0;
        apply_stimulus(1'b1, 6'd9, 1'b1, STRONG_T, 16'h1, 16'h2, 1'b1, 1'b1, 16'h3);
        run_cycle();
        check_output("rst_upd", update_enable, 0);
        check_output("rst_mis", mispredict, 0);
        check_output("rst_redir", redirect_pc, 0);
        check_output("rst_occ", occupancy, 0);
        check_output("rst_ready", predict_ready, 0);
        sync_rst_n = 1'b1;
        clk_en     = 1'b1;
        idle();
        run_cycle();

        // Random traffic; a narrow destination set makes matches and mismatches both common.
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 300; i++) begin
                sync_rst_n = ($urandom_range(0, 99) != 0);
                clk_en     = ($urandom_range(0, 9) != 0);
                apply_stimulus($urandom_range(0, 2) != 0,
                               6'($urandom),
                               1'($urandom),
                               2'($urandom),
                               ($urandom_range(0, 1) != 0) ? 16'h0040 : 16'h0080,
                               16'($urandom),
                               (phase == 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 4) == 0),
                               1'($urandom),
                               ($urandom_range(0, 1) != 0) ? 16'h0040 : 16'h0080);
                run_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolution_queue.md
# branch_resolution_queue

In-order queue of outstanding branch predictions between fetch and execute. Each prediction the branch target buffer makes at fetch is recorded here. When execute resolves the oldest branch, the block compares the actual outcome with the recorded prediction, raises a mispredict/redirect to fetch, and drives the buffer's update port (address, destination, taken) one cycle later.

## Interface
Parameters:
- DATABITWIDTH, 16, PC/destination width
- PREDICTORDEPTH, 64, target-buffer entries
- PREDICTORINDEXBITWIDTH, clog2(PREDICTORDEPTH) (1 if depth 1), buffer index width
- QUEUEDEPTH, 8, outstanding branches (power of two, ≥2)
- QUEUEINDEXBITWIDTH, clog2(QUEUEDEPTH), pointer width

Ports:
- clk  in  1  clock, all state on rising edge
- sync_rst_n  in  1  reset, synchronous, active-low
- clk_en  in  1  global enable; low freezes every register, handshakes ignored
- PredictValid  in  1  fetch offers a prediction record
- PredictReady  out  1  record accepted this cycle when both high
- PredictAddress  in  PREDICTORINDEXBITWIDTH  buffer index used at fetch
- PredictionValidIn  in  1  buffer hit
- PredictionIn  in  2  buffer 2-bit state; MSB = predicted taken
- PredictedDestinationIn  in  DATABITWIDTH  predicted target
- FallthroughPC  in  DATABITWIDTH  PC of next sequential instruction
- ResolveValid  in  1  execute resolves oldest branch
- ResolveTaken  in  1  actual direction
- ResolveDestination  in  DATABITWIDTH  actual target
- UpdateEnable  out  1  one-cycle update pulse to buffer
- UpdateAddress  out  PREDICTORINDEXBITWIDTH  index to update
- UpdateDestination  out  DATABITWIDTH  actual target
- UpdateTaken  out  1  actual direction
- Mispredict  out  1  one-cycle redirect pulse
- RedirectPC  out  DATABITWIDTH  correct next PC
- ResolveUnderflow  out  1  one-cycle pulse: resolve while empty
- Occupancy  out  QUEUEINDEXBITWIDTH+1  valid entries
- QueueEmpty / QueueFull  out  1 each  status

## Operation
- Entry = {address, hit, prediction[1:0], predicted dest, fallthrough}. Circular buffer; head/tail pointers one bit wider than index; full = MSBs differ and indices equal.
- PredictReady = sync_rst_n & !QueueFull. No bypass: a full queue refuses a record even if a resolve pops the same cycle.
- Enqueue on clk_en & PredictValid & PredictReady: write at tail, tail+1.
- Resolve on clk_en & ResolveValid & !QueueEmpty: read head, head+1. Resolve while empty: no pop, ResolveUnderflow pulses next cycle. Resolve and enqueue to empty queue in the same cycle: resolve is an underflow; the enqueue still lands.
- PredTaken = hit & prediction[1]. Mispredict = (PredTaken != ResolveTaken) | (PredTaken & ResolveTaken & PredictedDest != ResolveDestination).
- RedirectPC = ResolveTaken ? ResolveDestination : fallthrough.
- On mispredict: queue flushed (head = tail = 0); a same-cycle enqueue is dropped.
- Every valid resolve produces an update: UpdateAddress = entry address, UpdateDestination = ResolveDestination, UpdateTaken = ResolveTaken. The buffer applies its own state update.
- Occupancy = tail − head (wrap-aware); equals QUEUEDEPTH when full.

## Timing
- Status outputs and PredictReady are combinational from registers (PredictReady also from reset).
- Update*, Mispredict, RedirectPC, ResolveUnderflow are registered: asserted the cycle after the resolve and cleared the following enabled cycle unless a new resolve occurs.
- clk_en low holds all registers, including pulse outputs. The buffer also gates on clk_en, so held pulses cause no double update.
- Reset: sync_rst_n low at an edge forces pointers to 0; UpdateEnable, Mispredict, ResolveUnderflow, UpdateTaken = 0; UpdateAddress, UpdateDestination, RedirectPC = 0; PredictReady = 0 during reset; QueueEmpty = 1, QueueFull = 0, Occupancy = 0. Reset mid-operation discards all entries and wins over clk_en low.
- Entry storage needs no reset.

## Structure
- Shared package branch_pred_pkg: typedef branch_queue_entry_t (packed entry struct) and the prediction-state encoding constants (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11).
- One combinational sub-module, branch_outcome_compare: takes entry + resolve inputs, outputs Mispredict and RedirectPC. It is reusable by execute-side checking.

## Test plan
- Reset, then enqueue 8 records without resolve → QueueFull=1, Occupancy=8, PredictReady=0; the 9th record is not accepted.
- Enqueue {addr 5, hit 1, pred 11, dest 0x0040}; resolve taken/0x0040 → next cycle UpdateEnable=1, UpdateAddress=5, UpdateTaken=1, Mispredict=0.
- Same entry resolved taken to 0x0080 → Mispredict=1, RedirectPC=0x0080, queue empty afterwards.
- Entry {hit 0, fallthrough 0x0012} resolved not-taken → no mispredict. Resolve taken/0x0100 instead → Mispredict=1, RedirectPC=0x0100.
- ResolveValid while empty → ResolveUnderflow=1 for one cycle, no UpdateEnable. Separately, mispredict with a same-cycle enqueue → Occupancy=0.
- Pointer wrap: 20 interleaved enqueue/resolve pairs → updates emitted in FIFO order with correct addresses. clk_en low for 3 cycles holds all outputs unchanged. sync_rst_n low mid-stream → all outputs return to reset values the next cycle.
